// File: rtl/bundle_queue_pkg.sv
// Shared helpers for bundle queues and the decode/rename lane logic.
package bundle_queue_pkg;

    localparam int unsigned MAX_LANES = 32;

    // Ones in v[n-1:0]; lanes at or above n are ignored.
    function automatic int unsigned prefix_count(input logic [MAX_LANES-1:0] v,
                                                 input int unsigned n);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < n && v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/bundle_queue_if.sv
// Enqueue/dequeue handshake bundle for bundle_queue.
interface bundle_queue_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IN    = 4,
    parameter int unsigned OUT   = 2,
    localparam int unsigned PW   = $clog2(DEPTH) + 1
);
    logic [IN-1:0]        in_valid;
    logic [IN*WIDTH-1:0]  in_data;
    logic                 in_ready;
    logic [IN*PW-1:0]     in_id;
    logic [OUT-1:0]       out_valid;
    logic [OUT*WIDTH-1:0] out_data;
    logic [OUT*PW-1:0]    out_id;
    logic [OUT-1:0]       out_ready;
    logic [PW-1:0]        count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, in_id, out_valid, out_data, out_id, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, in_id, out_valid, out_data, out_id, count
    );
endinterface

// File: rtl/bundle_queue_lane_compact.sv
// Exclusive prefix popcount of lane valids plus total; gives compacted write offsets.
module bundle_queue_lane_compact
    import bundle_queue_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 5
) (
    input  logic [N-1:0]   valid,
    output logic [N*W-1:0] offset,
    output logic [W-1:0]   total
);
    always_comb begin
        logic [MAX_LANES-1:0] v_ext;
        v_ext          = '0;
        v_ext[N-1:0]   = valid;
        offset         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            offset[i*W +: W] = W'(prefix_count(v_ext, i));
        end
        total = W'(prefix_count(v_ext, N));
    end
endmodule

// File: rtl/bundle_queue.sv
// Multi-port circular queue for pipeline bundles with flush and tail truncation.
module bundle_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IN    = 4,
    parameter int unsigned OUT   = 2,
    localparam int unsigned PW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          trunc,
    input  logic [PW-1:0] trunc_id,
    bundle_queue_if.slave q
);
    localparam int unsigned IW = PW - 1;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [PW-1:0]    occ, free_slots, npop, trunc_off, kept;
    logic [IN*PW-1:0] lane_off;
    logic [PW-1:0]    lane_total;
    logic [OUT-1:0]   out_valid;
    logic             enq_fire, trunc_ok;

    // Wrap bit makes tail-head exact for 0..DEPTH occupied entries.
    assign occ        = tail_q - head_q;
    assign free_slots = PW'(DEPTH) - occ;
    assign q.in_ready = free_slots >= PW'(IN);
    assign q.count    = occ;
    assign q.out_valid = out_valid;
    assign enq_fire   = q.in_ready & ~flush & ~trunc;
    assign trunc_off  = trunc_id - head_q;
    assign trunc_ok   = trunc_off < occ;
    assign kept       = trunc_off + PW'(1);

    bundle_queue_lane_compact #(.N(IN), .W(PW)) u_lane_compact (
        .valid  (q.in_valid),
        .offset (lane_off),
        .total  (lane_total)
    );

    always_comb begin
        logic [PW-1:0] rptr;
        out_valid  = '0;
        q.out_data = '0;
        q.out_id   = '0;
        q.in_id    = '0;
        for (int unsigned i = 0; i < OUT; i++) begin
            rptr                        = head_q + PW'(i);
            out_valid[i]                = PW'(i) < occ;
            q.out_id[i*PW +: PW]        = rptr;
            q.out_data[i*WIDTH +: WIDTH] = mem_q[rptr[IW-1:0]];
        end
        for (int unsigned i = 0; i < IN; i++) begin
            q.in_id[i*PW +: PW] = tail_q + lane_off[i*PW +: PW];
        end
    end

    // Only the unbroken run of accepted lanes from lane 0 is consumed.
    always_comb begin
        logic run;
        run  = 1'b1;
        npop = '0;
        for (int unsigned i = 0; i < OUT; i++) begin
            run = run & out_valid[i] & q.out_ready[i];
            if (run) npop = npop + PW'(1);
        end
    end

    always_comb begin
        head_d = head_q + npop;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else if (trunc) begin
            if (trunc_ok) begin
                tail_d = trunc_id + PW'(1);
                if (npop >= kept) head_d = tail_d;
            end
        end else if (enq_fire) begin
            tail_d = tail_q + lane_total;
        end
    end

    always_comb begin
        logic [PW-1:0] wptr;
        wptr = '0;
        for (int unsigned d = 0; d < DEPTH; d++) mem_d[d] = mem_q[d];
        if (enq_fire) begin
            for (int unsigned i = 0; i < IN; i++) begin
                if (q.in_valid[i]) begin
                    wptr = tail_q + lane_off[i*PW +: PW];
                    mem_d[wptr[IW-1:0]] = q.in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
